// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU and debug byte accesses onto one synchronous-read memory port.
// Define MEMARB_RR_EN for round-robin tie-breaking; otherwise the CPU wins every tie.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {CPU, DBG} owner_t;
  state_t state;
  owner_t last_owner;
  logic cpu_elig, dbg_elig, cpu_win;
  assign cpu_elig = cpu_req & ~dbg_halt;
  assign dbg_elig = dbg_req;
`ifdef MEMARB_RR_EN
  assign cpu_win = cpu_elig & (~dbg_elig | (last_owner == DBG));
`else
  assign cpu_win = cpu_elig;
`endif
  assign busy = state != IDLE;
  // last_owner doubles as the owner of the access in flight, since it is
  // updated on exactly the IDLE->ISSUE transition that latches that access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= DBG;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      case (state)
        IDLE: if (cpu_elig | dbg_elig) begin
          state      <= ISSUE;
          last_owner <= cpu_win ? CPU : DBG;
          cpu_gnt    <= cpu_win;
          dbg_gnt    <= ~cpu_win;
          mem_en     <= 1'b1;
          mem_we     <= cpu_win ? cpu_we : dbg_we;
          mem_addr   <= cpu_win ? cpu_addr : dbg_addr;
          mem_wdata  <= cpu_win ? cpu_wdata : dbg_wdata;
        end
        ISSUE: state <= mem_we ? IDLE : RESP;
        RESP: begin
          state <= IDLE;
          if (last_owner == CPU) begin
            cpu_rdata  <= mem_rdata;
            cpu_rvalid <= 1'b1;
          end else begin
            dbg_rdata  <= mem_rdata;
            dbg_rvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single unified byte-wide memory port shared by the multicycle CPU controller (instruction fetch, LB, SB) and the debug/program-loader port. Requests are accepted, serialised, and issued to a synchronous-read memory one at a time. Each requester receives a grant pulse and, for reads, a registered read-data return. It sits between the CPU datapath's memory address mux and the memory macro.

## Interface
- ADDR_W, 32, memory address width
- DATA_W, 8, memory data width (byte access)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1 = write (SB), 0 = read (fetch/LB)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU access issued to memory
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  registered read data, held until next CPU read completes
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug-port request, same rules as CPU
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  debug-port grant/response, same rules as CPU
- dbg_halt  in  1  level; while high, no new CPU grants are issued
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: eligible requesters are dbg_req, and cpu_req & ~dbg_halt. If none, stay. Otherwise pick a winner (see Configuration), latch owner, we, addr, wdata into internal registers, go to ISSUE.
- ISSUE: mem_en=1; mem_we/mem_addr/mem_wdata come from the latched registers. The owner's gnt=1. Go to RESP if the access is a read, otherwise go to IDLE.
- RESP: capture mem_rdata into the owner's rdata register at the end of the cycle. Set the owner's rvalid for the following cycle. Go to IDLE.
- A requester must treat gnt as consuming its request. If req is still high when the arbiter is next in IDLE, it counts as a new request.
- Request inputs are sampled only in IDLE. Changes to req, addr, or data in ISSUE or RESP are ignored.
- dbg_halt is sampled only in IDLE. Raising it does not cancel a CPU access already latched.
- The non-owner's rdata register is never modified.
- last_owner register: updated to the winner on every IDLE→ISSUE transition.

## Timing
- Reset values: state=IDLE, all gnt/rvalid=0, cpu_rdata=dbg_rdata=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, busy=0, last_owner=DBG.
- mem_en, mem_we, mem_addr and mem_wdata are 0 whenever state != ISSUE.
- Read latency, counting from the cycle req is sampled in IDLE as cycle 0:
  - cycle 1: ISSUE, gnt=1
  - cycle 2: RESP
  - cycle 3: rvalid=1 with valid rdata; the arbiter is in IDLE and may arbitrate in the same cycle
- Write latency: cycle 1 is ISSUE with gnt=1; the memory is written at the end of cycle 1; the arbiter is back in IDLE in cycle 2.
- Maximum throughput: one write per 2 cycles, one read per 3 cycles.
- rst asserted mid-operation: immediate return to reset values. A pending rvalid is dropped and a latched access is discarded. An access in ISSUE is not guaranteed to complete.
- gnt and rvalid are never high for both ports in the same cycle.
- gnt and rvalid for the same port are never high together.

## Configuration
- MEMARB_RR_EN defined: round-robin arbitration. On simultaneous eligible requests the port that is not last_owner wins. With last_owner resetting to DBG, the CPU wins the first tie.
- MEMARB_RR_EN undefined: fixed priority, CPU always wins a tie. last_owner is still maintained but does not affect selection. The debug port is served only when the CPU is not requesting or is halted.

## Test plan
- After rst release, CPU read of addr 0x10 with memory holding 0xA5 → cpu_gnt in cycle 1, cpu_rvalid in cycle 3 with cpu_rdata=0xA5; mem_en high only in cycle 1.
- Debug write 0x3C to 0x20, then CPU read of 0x20 → memory written in ISSUE with mem_we=1; the CPU read returns 0x3C; dbg_rvalid never asserts.
- cpu_req and dbg_req both held high continuously:
  - with MEMARB_RR_EN: grants alternate CPU, DBG, CPU, DBG.
  - without MEMARB_RR_EN: only cpu_gnt pulses.
- dbg_halt=1 with cpu_req=1 and dbg_req=0 for 10 cycles → no cpu_gnt and busy=0. Drop dbg_halt → cpu_gnt in the next ISSUE cycle.
- Assert rst during RESP of a CPU read → cpu_rvalid stays 0, cpu_rdata=0, state IDLE, mem_en=0. After release, the re-issued read completes normally.
- Change cpu_addr from 0x10 to 0x99 during ISSUE → mem_addr stays 0x10 for that access.
